// File: rtl/core_c1_wback_pkg.sv
// ----------------------------------------------------------------------------
// core_c1_wback_pkg
// Shared core parameters and types for the write-back stage.
//   XLEN       : data path width
//   REG_IDX_W  : register index width
//   LDQ_DEPTH  : pending-load index queue depth
// ----------------------------------------------------------------------------
package core_c1_wback_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned LDQ_DEPTH = 4;
    localparam int unsigned LDQ_PTR_W = $clog2(LDQ_DEPTH);
    localparam int unsigned NUM_REGS  = 1 << REG_IDX_W;

    // Queue occupancy value meaning "full"
    localparam logic [LDQ_PTR_W:0] LDQ_CNT_FULL = LDQ_DEPTH[LDQ_PTR_W:0];

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xdata_t;

    typedef struct packed {
        reg_idx_t idx;
        xdata_t   data;
    } wb_t;

    // Source of the register-file write launched in the current cycle
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LOAD,
        WB_HOLD
    } wb_src_e;

    // x0 is hardwired: it never holds a result and never creates a dependency
    function automatic logic idx_live(input reg_idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/core_c1_wback_idxq.sv
// ----------------------------------------------------------------------------
// core_c1_wb_idxq
// In-order FIFO of register indices with occupancy count.
// Push while full and pop while empty are ignored.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : enqueue i_din
//   i_din      : index to enqueue
//   i_pop      : dequeue head
//   o_dout     : head entry (valid when !o_empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_count    : number of entries held
// ----------------------------------------------------------------------------
module core_c1_wb_idxq
    import core_c1_wback_pkg::*;
#(
    parameter int unsigned DEPTH = LDQ_DEPTH,
    parameter int unsigned W     = REG_IDX_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers wrap naturally: DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/core_c1_wback.sv
// ----------------------------------------------------------------------------
// core_c1_wback
// Write-back stage: merges single-cycle ALU results and in-order load
// responses onto one registered register-file write port, tracks pending
// load destinations for decode hazard detection.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   alu_valid/alu_idx/alu_data        : ALU result (highest write priority)
//   ld_issue/ld_issue_idx             : load issued, destination reserved
//   ld_issue_ready                    : load-index queue not full
//   ld_resp_valid/ld_resp_data        : in-order load response
//   ld_resp_ready                     : response accepted (hold register free)
//   chk_rs1_idx/chk_rs2_idx/chk_rd_idx: decode-stage operand indices
//   hazard                            : decode must stall (RAW/WAW on a load)
//   rd_valid/rd_idx/rd_data           : registered register-file write port
// ----------------------------------------------------------------------------
module core_c1_wback
    import core_c1_wback_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     alu_valid,
    input  reg_idx_t alu_idx,
    input  xdata_t   alu_data,
    input  logic     ld_issue,
    input  reg_idx_t ld_issue_idx,
    output logic     ld_issue_ready,
    input  logic     ld_resp_valid,
    input  xdata_t   ld_resp_data,
    output logic     ld_resp_ready,
    input  reg_idx_t chk_rs1_idx,
    input  reg_idx_t chk_rs2_idx,
    input  reg_idx_t chk_rd_idx,
    output logic     hazard,
    output logic     rd_valid,
    output reg_idx_t rd_idx,
    output xdata_t   rd_data
);

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [LDQ_PTR_W:0]  w_count;
    reg_idx_t            w_head_idx;
    logic                w_resp_acc;
    logic                w_to_hold;
    wb_src_e             w_src;
    wb_t                 w_wb;
    logic [NUM_REGS-1:0] w_busy_nxt;

    logic [NUM_REGS-1:0] r_busy;
    logic                r_hold_valid;
    wb_t                 r_hold;
    logic                r_rd_valid;
    reg_idx_t            r_rd_idx;
    xdata_t              r_rd_data;
    logic                r_rd_load;

    // A response is taken only with a free hold slot and a matching queue entry
    assign w_resp_acc = ld_resp_valid && !r_hold_valid && !w_empty;
    assign w_pop      = w_resp_acc;
    assign w_push     = ld_issue && !w_full;
    assign w_to_hold  = w_resp_acc && alu_valid;

    core_c1_wb_idxq #(
        .DEPTH (LDQ_DEPTH),
        .W     (REG_IDX_W)
    ) u_idxq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (ld_issue_idx),
        .i_pop   (w_pop),
        .o_dout  (w_head_idx),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assert property (@(posedge clk) disable iff (!rst_n) w_count <= LDQ_CNT_FULL);

    assign ld_issue_ready = !w_full;
    assign ld_resp_ready  = !r_hold_valid;

    assign hazard = (idx_live(chk_rs1_idx) && r_busy[chk_rs1_idx]) ||
                    (idx_live(chk_rs2_idx) && r_busy[chk_rs2_idx]) ||
                    (idx_live(chk_rd_idx)  && r_busy[chk_rd_idx]);

    // Write-port arbitration: ALU, then a held load, then a fresh response
    always_comb begin
        w_src = WB_NONE;
        w_wb  = '0;
        if (alu_valid) begin
            w_src = WB_ALU;
            w_wb  = '{idx: alu_idx, data: alu_data};
        end else if (r_hold_valid) begin
            w_src = WB_HOLD;
            w_wb  = r_hold;
        end else if (w_resp_acc) begin
            w_src = WB_LOAD;
            w_wb  = '{idx: w_head_idx, data: ld_resp_data};
        end
    end

    // Busy bit is released once the load write has been presented on rd_*
    // (i.e. the register file holds the value); a new reservation wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rd_load) begin
            w_busy_nxt[r_rd_idx] = 1'b0;
        end
        if (w_push && idx_live(ld_issue_idx)) begin
            w_busy_nxt[ld_issue_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_idx     <= '0;
            r_rd_data    <= '0;
            r_rd_load    <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;

            if (w_to_hold) begin
                r_hold_valid <= 1'b1;
                r_hold       <= '{idx: w_head_idx, data: ld_resp_data};
            end else if (w_src == WB_HOLD) begin
                r_hold_valid <= 1'b0;
            end

            r_rd_valid <= (w_src != WB_NONE) && idx_live(w_wb.idx);
            r_rd_load  <= ((w_src == WB_LOAD) || (w_src == WB_HOLD)) && idx_live(w_wb.idx);
            if (w_src != WB_NONE) begin
                r_rd_idx  <= w_wb.idx;
                r_rd_data <= w_wb.data;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_idx   = r_rd_idx;
    assign rd_data  = r_rd_data;

endmodule
